// File: rtl/dmem_loader_if.sv
// Shared bus bundle for dmem_loader: LOAD input stream, DUMP output stream,
// CPU-side memory request and the single data-memory port.
interface dmem_loader_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;

  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;

  logic        cpu_mem_write;
  logic        cpu_mem_read;
  logic [31:0] cpu_address;
  logic [31:0] cpu_write_data;
  logic [31:0] cpu_read_data;

  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  // The loader itself
  modport slave (
    input  s_valid, s_data,
    output s_ready,
    output m_valid, m_data,
    input  m_ready,
    input  cpu_mem_write, cpu_mem_read, cpu_address, cpu_write_data,
    output cpu_read_data,
    output mem_write, mem_read, mem_address, mem_write_data,
    input  mem_read_data
  );

  // Everything around it: stream endpoints, CPU and data memory
  modport master (
    output s_valid, s_data,
    input  s_ready,
    input  m_valid, m_data,
    output m_ready,
    output cpu_mem_write, cpu_mem_read, cpu_address, cpu_write_data,
    input  cpu_read_data,
    input  mem_write, mem_read, mem_address, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_loader.sv
// Bulk LOAD/DUMP engine muxed in front of the data memory; CPU passes straight through when idle.
// LOAD writes 1 word/cycle on s_valid; DUMP yields 1 word per 2 cycles, m_data held while m_ready is low.
module dmem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned DEPTH     = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [12:0]   count,
  input  logic          abort,
  dmem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          cpu_stall
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DUMP_FETCH,
    DUMP_WAIT,
    DONE
  } state_t;

  localparam logic [12:0] DEPTH_W = 13'(DEPTH);

  state_t      state_q, state_d;
  logic [12:0] idx_q, idx_d;
  logic [12:0] cnt_q, cnt_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;

  logic [12:0] count_clamped;
  logic        last_word;
  logic [31:0] word_addr;
  logic        active;

  assign count_clamped = (count > DEPTH_W) ? DEPTH_W : count;
  assign last_word     = (idx_q == cnt_q - 13'd1);
  assign word_addr     = BASE_ADDR + {17'd0, idx_q, 2'b00};
  assign active        = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = count_clamped;
          idx_d = '0;
          if (count_clamped == 13'd0) state_d = DONE;
          else if (mode)              state_d = DUMP_FETCH;
          else                        state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.s_valid) begin
          idx_d = idx_q + 13'd1;
          if (last_word) state_d = DONE;
        end
      end
      DUMP_FETCH: begin
        m_data_d  = bus.mem_read_data;
        m_valid_d = 1'b1;
        state_d   = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          if (last_word) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 13'd1;
            state_d = DUMP_FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition; a LOAD write in this cycle still lands
    // because the memory strobe below is driven from the current state.
    if (active && abort) begin
      state_d   = IDLE;
      m_valid_d = 1'b0;
    end
  end

  always_comb begin
    busy      = active;
    cpu_stall = active;
    done      = (state_q == DONE);

    bus.s_ready = (state_q == LOAD);
    bus.m_valid = m_valid_q;
    bus.m_data  = m_data_q;

    if (!active) begin
      bus.mem_write      = bus.cpu_mem_write;
      bus.mem_read       = bus.cpu_mem_read;
      bus.mem_address    = bus.cpu_address;
      bus.mem_write_data = bus.cpu_write_data;
      bus.cpu_read_data  = bus.mem_read_data;
    end else begin
      bus.mem_write      = (state_q == LOAD) && bus.s_valid;
      bus.mem_read       = (state_q == DUMP_FETCH);
      bus.mem_address    = word_addr;
      bus.mem_write_data = bus.s_data;
      bus.cpu_read_data  = '0;
    end
  end

endmodule

// File: tb/tb_dmem_loader.sv
// Randomized bench for dmem_loader: a transaction-level model (word counter, shadow memory,
// pending dump word) predicts every output each cycle; directed scenarios pin literal values.
module tb_dmem_loader;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [12:0] count;
  logic        abort;
  logic        busy;
  logic        done;
  logic        cpu_stall;

  dmem_loader_if bus ();

  dmem_loader #(.BASE_ADDR(BASE), .DEPTH(4096)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .count     (count),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .cpu_stall (cpu_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h4000);
  endfunction

  function automatic logic [11:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[13:2];
  endfunction

  function automatic logic [12:0] clamp(input logic [12:0] c);
    return (c > 13'd4096) ? 13'd4096 : c;
  endfunction

  // ---------------- data memory attached to the DUT ----------------
  logic [31:0] mem_arr [0:4095];

  always_comb begin
    bus.mem_read_data = in_range(bus.mem_address) ? mem_arr[widx(bus.mem_address)] : 32'h0;
  end

  always @(posedge clk) begin
    if (bus.mem_write && in_range(bus.mem_address))
      mem_arr[widx(bus.mem_address)] <= bus.mem_write_data;
  end

  // ---------------- transaction-level reference model ----------------
  typedef enum int {M_IDLE, M_LOAD, M_DUMP, M_FIN} mstate_t;
  mstate_t     ms;
  logic [12:0] mk;       // words completed so far in this operation
  logic [12:0] mn;       // words requested (after clamp)
  logic        mhave;    // a dump word is being presented
  logic [31:0] mdat;     // last dump word presented
  logic [31:0] shadow [0:4095];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms    <= M_IDLE;
      mk    <= '0;
      mn    <= '0;
      mhave <= 1'b0;
      mdat  <= '0;
    end else begin
      case (ms)
        M_IDLE: begin
          if (bus.cpu_mem_write && in_range(bus.cpu_address))
            shadow[widx(bus.cpu_address)] <= bus.cpu_write_data;
          if (start) begin
            mn <= clamp(count);
            mk <= '0;
            ms <= (clamp(count) == 13'd0) ? M_FIN : (mode ? M_DUMP : M_LOAD);
          end
        end
        M_LOAD: begin
          if (bus.s_valid) begin
            shadow[mk[11:0]] <= bus.s_data;
            mk <= mk + 13'd1;
            if (mk + 13'd1 == mn) ms <= M_FIN;
          end
        end
        M_DUMP: begin
          if (!mhave) begin
            mhave <= 1'b1;
            mdat  <= shadow[mk[11:0]];
          end else if (bus.m_ready) begin
            mhave <= 1'b0;
            mk    <= mk + 13'd1;
            if (mk + 13'd1 == mn) ms <= M_FIN;
          end
        end
        default: ms <= M_IDLE;
      endcase
      if (ms != M_IDLE && abort) begin
        ms    <= M_IDLE;
        mhave <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare + monitors ----------------
  logic [31:0] got [$];
  int          nwr;
  logic [31:0] last_addr;

  initial begin
    nwr = 0;
    last_addr = '0;
    forever begin
      @(negedge clk);
      chk1("busy", busy, ms != M_IDLE);
      chk1("cpu_stall", cpu_stall, ms != M_IDLE);
      chk1("done", done, ms == M_FIN);
      chk1("s_ready", bus.s_ready, ms == M_LOAD);
      chk1("m_valid", bus.m_valid, mhave);
      chk("m_data", bus.m_data, mdat);
      if (ms == M_IDLE) begin
        chk1("pt_write", bus.mem_write, bus.cpu_mem_write);
        chk1("pt_read", bus.mem_read, bus.cpu_mem_read);
        chk("pt_addr", bus.mem_address, bus.cpu_address);
        chk("pt_wdata", bus.mem_write_data, bus.cpu_write_data);
        chk("pt_rdata", bus.cpu_read_data,
            in_range(bus.cpu_address) ? shadow[widx(bus.cpu_address)] : 32'h0);
      end else begin
        chk("cpu_rdata_blocked", bus.cpu_read_data, 32'h0);
        case (ms)
          M_LOAD: begin
            chk1("load_write", bus.mem_write, bus.s_valid);
            chk1("load_read", bus.mem_read, 1'b0);
            chk("load_addr", bus.mem_address, BASE + 32'(mk) * 32'd4);
            if (bus.s_valid) chk("load_wdata", bus.mem_write_data, bus.s_data);
          end
          M_DUMP: begin
            chk1("dump_write", bus.mem_write, 1'b0);
            chk1("dump_read", bus.mem_read, !mhave);
            chk("dump_addr", bus.mem_address, BASE + 32'(mk) * 32'd4);
          end
          default: begin
            chk1("fin_write", bus.mem_write, 1'b0);
            chk1("fin_read", bus.mem_read, 1'b0);
          end
        endcase
      end
      if (rst_n && bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
      if (rst_n && busy && bus.mem_write) begin
        nwr++;
        last_addr = bus.mem_address;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; mode = 1'b0; count = '0; abort = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    bus.cpu_mem_write = 1'b0; bus.cpu_mem_read = 1'b0;
    bus.cpu_address = '0; bus.cpu_write_data = '0;
  endtask

  task automatic pulse_start(input logic md, input logic [12:0] c);
    start = 1'b1; mode = md; count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    bus.cpu_mem_write = 1'b1; bus.cpu_address = a; bus.cpu_write_data = d;
    tick();
    bus.cpu_mem_write = 1'b0;
  endtask

  initial begin
    int k;
    int guard;
    int lowc;
    for (int i = 0; i < 4096; i++) begin
      mem_arr[i] = 32'h0;
      shadow[i]  = 32'h0;
    end
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_s_ready", bus.s_ready, 1'b0);
    chk("reset_m_data", bus.m_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // CPU pass-through while idle
    cpu_write(32'h1001_0010, 32'hDEAD_BEEF);
    bus.cpu_mem_read = 1'b1; bus.cpu_address = 32'h1001_0010;
    #2;
    chk("idle_readback", bus.cpu_read_data, 32'hDEAD_BEEF);
    tick();
    bus.cpu_mem_read = 1'b0;

    // LOAD of 4 words with s_valid on every other cycle
    pulse_start(1'b0, 13'd4);
    k = 0; guard = 0;
    while (k < 4 && guard < 50) begin
      bus.s_valid = guard[0];
      bus.s_data  = 32'hA0 + 32'(k);
      tick();
      if (bus.s_valid) k++;
      guard++;
    end
    bus.s_valid = 1'b0;
    chk1("gap_load_done", done, 1'b1);
    tick();
    chk1("gap_load_done_once", done, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("gap_word%0d", i), mem_arr[i], 32'hA0 + 32'(i));

    // DUMP of 3 words, consumer stalls 3 cycles on word 1, CPU write and re-start ignored
    cpu_write(32'h1001_0000, 32'h11);
    cpu_write(32'h1001_0004, 32'h22);
    cpu_write(32'h1001_0008, 32'h33);
    got.delete();
    pulse_start(1'b1, 13'd3);
    start = 1'b1; mode = 1'b0; count = 13'd7;
    bus.cpu_mem_write = 1'b1; bus.cpu_address = 32'h1001_0010; bus.cpu_write_data = 32'h0BAD_BAD0;
    lowc = 0; guard = 0;
    while (ms != M_IDLE && guard < 100) begin
      if (guard == 1) begin
        start = 1'b0;
        bus.cpu_mem_write = 1'b0;
      end
      if (got.size() == 1 && lowc < 3 && bus.m_valid) begin
        bus.m_ready = 1'b0;
        lowc++;
        chk("dump_hold", bus.m_data, 32'h22);
      end else begin
        bus.m_ready = 1'b1;
      end
      tick();
      guard++;
    end
    idle_inputs();
    chk1("dump_in_time", guard < 100, 1'b1);
    chk("dump_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("dump_w0", got[0], 32'h11);
      chk("dump_w1", got[1], 32'h22);
      chk("dump_w2", got[2], 32'h33);
    end
    chk("dump_cpu_blocked", mem_arr[4], 32'hDEAD_BEEF);

    // count == 0
    pulse_start(1'b0, 13'd0);
    chk1("zero_done", done, 1'b1);
    tick();
    chk1("zero_done_once", done, 1'b0);

    // abort while waiting on the consumer
    pulse_start(1'b1, 13'd5);
    tick();
    chk1("abort_pre_mvalid", bus.m_valid, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_mvalid", bus.m_valid, 1'b0);
    chk1("abort_done", done, 1'b0);
    tick();

    // reset in the middle of a 10-word LOAD after 5 words
    pulse_start(1'b0, 13'd10);
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_data = 32'h500 + 32'(i);
      tick();
    end
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_s_ready", bus.s_ready, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_w0", mem_arr[0], 32'h500);
    chk("midrst_w4", mem_arr[4], 32'h504);

    // randomized operations interleaved with idle CPU traffic
    for (int op = 0; op < 40; op++) begin
      int n_idle;
      int pv;
      int pr;
      logic do_ab;
      n_idle = $urandom_range(1, 4);
      for (int c = 0; c < n_idle; c++) begin
        bus.cpu_mem_write  = 1'($urandom_range(0, 1));
        bus.cpu_mem_read   = !bus.cpu_mem_write && ($urandom_range(0, 1) == 1);
        bus.cpu_address    = BASE + 32'($urandom_range(0, 63)) * 32'd4;
        bus.cpu_write_data = $urandom;
        tick();
      end
      idle_inputs();
      pv = $urandom_range(30, 100);
      pr = $urandom_range(30, 100);
      do_ab = ($urandom_range(0, 3) == 0);
      pulse_start(1'($urandom_range(0, 1)), 13'($urandom_range(0, 24)));
      guard = 0;
      while (ms != M_IDLE && guard < 300) begin
        bus.s_valid = ($urandom_range(0, 99) < pv);
        bus.s_data  = $urandom;
        bus.m_ready = ($urandom_range(0, 99) < pr);
        abort       = do_ab && ($urandom_range(0, 99) < 3);
        start       = ($urandom_range(0, 19) == 0);
        mode        = 1'($urandom_range(0, 1));
        count       = 13'($urandom_range(0, 24));
        bus.cpu_mem_write  = 1'($urandom_range(0, 1));
        bus.cpu_mem_read   = 1'($urandom_range(0, 1));
        bus.cpu_address    = BASE + 32'($urandom_range(0, 63)) * 32'd4;
        bus.cpu_write_data = $urandom;
        tick();
        guard++;
      end
      idle_inputs();
      chk1("rand_op_in_time", guard < 300, 1'b1);
    end

    // oversize LOAD clamps to the full memory
    nwr = 0;
    pulse_start(1'b0, 13'd5000);
    bus.s_valid = 1'b1;
    guard = 0;
    while (ms != M_IDLE && guard < 5000) begin
      bus.s_data = $urandom;
      tick();
      guard++;
    end
    idle_inputs();
    chk1("big_in_time", guard < 5000, 1'b1);
    chk("big_writes", 32'(nwr), 32'd4096);
    chk("big_last_addr", last_addr, 32'h1001_3FFC);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_loader.md
# dmem_loader

Bulk loader/dumper sitting directly upstream of the data memory, sharing its single write/read port with the CPU datapath. When idle it passes CPU memory traffic straight through. When started, it stalls the CPU and either streams words from an external valid/ready source into consecutive data-memory words starting at `BASE_ADDR` (LOAD), or streams them back out (DUMP). This is how the bucket-sort input array is preloaded and the sorted result is read back.

## Interface
- `BASE_ADDR`, default 32'h10010000: byte address of word index 0.
- `DEPTH`, default 4096: data-memory size in words.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request, sampled only in IDLE.
- `mode` in 1: 0 = LOAD, 1 = DUMP; sampled with `start`.
- `count` in 13: number of words, sampled with `start`. Values above `DEPTH` clamp to `DEPTH`.
- `abort` in 1: return to IDLE without asserting `done`.
- `s_valid` in 1, `s_data` in 32, `s_ready` out 1: LOAD input stream.
- `m_valid` out 1, `m_data` out 32, `m_ready` in 1: DUMP output stream.
- `busy` out 1, `done` out 1, `cpu_stall` out 1: status outputs.
- `cpu_mem_write` in 1, `cpu_mem_read` in 1, `cpu_address` in 32, `cpu_write_data` in 32: CPU request.
- `cpu_read_data` out 32: CPU read return.
- `mem_write` out 1, `mem_read` out 1, `mem_address` out 32, `mem_write_data` out 32: to the data memory.
- `mem_read_data` in 32: from the data memory; combinational read, valid in the same cycle.

## Operation
- States: IDLE, LOAD, DUMP_FETCH, DUMP_WAIT, DONE. Word index register `idx` is 13 bits. Latched count `cnt` is 13 bits.
- IDLE:
  - Memory port = CPU signals, pure combinational pass-through.
  - `cpu_read_data` = `mem_read_data`.
- IDLE with `start`:
  - Latch `cnt` = min(`count`, `DEPTH`) and set `idx` = 0.
  - If `cnt` == 0, go to DONE.
  - Else go to LOAD (mode 0) or DUMP_FETCH (mode 1).
- Any non-IDLE state:
  - CPU request ignored; `cpu_read_data` = 0.
  - `mem_address` = `BASE_ADDR` + (`idx` << 2), 32-bit wrap.
- LOAD:
  - `s_ready` = 1.
  - On `s_valid`: `mem_write` = 1 and `mem_write_data` = `s_data` in that same cycle; `idx` increments.
  - When the accepted word has `idx` == `cnt`-1, go to DONE.
  - `mem_read` = 0.
- DUMP_FETCH:
  - `mem_read` = 1.
  - Capture `mem_read_data` into the `m_data` register, set `m_valid` = 1, go to DUMP_WAIT.
- DUMP_WAIT:
  - `mem_read` = 0; hold `m_data` and `m_valid`.
  - On `m_ready`, clear `m_valid`.
  - If `idx` == `cnt`-1, go to DONE; else increment `idx` and go to DUMP_FETCH.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `abort`, in any non-IDLE state:
  - Next state IDLE; `m_valid` cleared.
  - A LOAD handshake in the abort cycle still writes.
  - `abort` has priority over all other transitions; `done` is not asserted.
- `start` while not IDLE: ignored.
- `busy` = (state != IDLE). `cpu_stall` = `busy`.

## Timing
- Reset values:
  - State IDLE; `idx` and `cnt` = 0.
  - `m_valid` = 0, `m_data` = 0, `done` = 0.
  - `busy` = 0, `cpu_stall` = 0, `s_ready` = 0.
  - Memory port follows CPU pass-through.
- Reset mid-operation: immediate return to IDLE; no partial `done`. Words already written stay in memory.
- Start latency: `start` in cycle T puts the block in LOAD or DUMP_FETCH in T+1 (DONE in T+1 if `count` == 0, with `done` in T+1).
- LOAD throughput: 1 word per cycle. An N-word load with `s_valid` held high uses cycles T+1..T+N; `done` in T+N+1.
- DUMP throughput: 1 word per 2 cycles with `m_ready` held high. `m_data` is registered and stable while `m_valid` && !`m_ready`.
- `count` = 4096: indices 0..4095; last address `BASE_ADDR` + 0x3FFC.
- `count` > 4096: clamps to 4096; no wrap into index 0.

## Test plan
- Reset with `rst_n` = 0 mid-LOAD at word 5 of 10 -> outputs return to reset values the same cycle; words 0..4 remain in memory; `done` never pulses.
- LOAD `count` = 4 with data 0xA0..0xA3 and `s_valid` gapped every other cycle -> writes to 0x10010000..0x1001000C only on handshakes; `done` one cycle after the 4th write; `cpu_stall` high throughout.
- DUMP `count` = 3 of preloaded 0x11, 0x22, 0x33 with `m_ready` low for 3 cycles on word 1 -> `m_data` holds 0x22 stable; sequence 0x11, 0x22, 0x33 delivered; then `done`.
- `count` = 0 -> `done` in the cycle after `start`; no memory access. `count` = 5000 LOAD -> exactly 4096 writes; last write at 0x10013FFC.
- IDLE pass-through: CPU writes 0xDEADBEEF to 0x10010010 then reads it -> `cpu_read_data` = 0xDEADBEEF. During a DUMP, a CPU write to the same address is blocked and the memory value is unchanged.
- `abort` in DUMP_WAIT -> IDLE next cycle, `m_valid` = 0, no `done`. A second `start` issued while busy is ignored.
